rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
- Receive-side sequencer for the UART slave.
- Synchronises the serial line, detects and qualifies the start bit, and takes a 3-sample majority vote at the middle of each bit.
- Drives the shift/one/zero strobes of the receive SIPO, one strobe per data bit, LSB first.
- Checks optional parity and the stop bit, and flags frame completion or errors to the host side.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.
- DATA_BITS, 8, data bits per frame; range 5..8; must match the SIPO width in use.
- PARITY_EN, 0, 1 means one parity bit follows the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
- i_baudclk  input  1  block clock; all state updates on its rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_sample_tick  input  1  one-cycle enable at OVERSAMPLE x baud rate; all bit timing counts only these ticks.
- i_rx  input  1  raw serial line; asynchronous; idle level 1.
- o_shift  output  1  one-cycle SIPO shift strobe.
- o_onedetected  output  1  voted bit is 1; valid only with o_shift.
- o_zerodetected  output  1  voted bit is 0; valid only with o_shift.
- o_data_valid  output  1  one-cycle pulse: SIPO holds a complete frame.
- o_parity_err  output  1  one-cycle pulse, coincident with o_data_valid.
- o_framing_err  output  1  one-cycle pulse: stop bit sampled as 0.
- o_busy  output  1  high from start-bit detection until the frame ends.

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; state IDLE; counters 0.
  - synchroniser flops preset to 1, so the line reads idle.
- Input path: i_rx passes through a 2-FF synchroniser; rx_s is the second stage. Adds 2 cycles of latency, no other filtering.
- Sample counter scnt: 0..OVERSAMPLE-1; advances only on i_sample_tick; wraps to 0.
- Majority vote:
  - samples taken on ticks where scnt = M-1, M and M+1, with M = OVERSAMPLE/2.
  - vote = majority of the 3 samples.
  - the decision is made on the tick where scnt = M+1.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - on a tick with rx_s = 0: go to START, scnt <= 1, o_busy <= 1.
- START:
  - at the decision tick, vote = 1 (false start): go to IDLE, o_busy <= 0, no strobe issued.
  - otherwise, on the tick where scnt wraps: go to DATA, bit counter bcnt <= 0.
- DATA:
  - one cycle after each decision tick: o_shift = 1 for exactly one cycle.
  - in that same cycle, exactly one of o_onedetected/o_zerodetected = 1, matching the vote.
  - running parity accumulates the voted bits.
  - at each scnt wrap: bcnt++.
  - after DATA_BITS bits: go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - at the decision tick: compare the voted bit with the running parity (even or odd per PARITY_ODD); latch the mismatch.
  - no SIPO strobe is issued for the parity bit.
  - at scnt wrap: go to STOP.
- STOP, one cycle after the decision tick:
  - vote = 1: o_data_valid = 1 for one cycle; o_parity_err = latched mismatch in that same cycle; go to IDLE; o_busy <= 0.
  - vote = 0: o_framing_err = 1 for one cycle; no o_data_valid; go to WAIT_IDLE.
  - both cases leave STOP at mid-stop-bit, which permits back-to-back frames with a half-bit margin.
- WAIT_IDLE:
  - stays until rx_s = 1 on a tick; this swallows breaks.
  - then go to IDLE, o_busy <= 0.
- Strobe exclusivity: o_shift, o_data_valid and o_framing_err are never high in the same cycle.
- Reset mid-frame: state and strobes clear immediately. The SIPO contents are stale; o_data_valid is never issued for a partial frame.
- i_sample_tick held low: the FSM freezes in place; strobes already scheduled still complete.
- i_rx toggling between votes: only the 3 mid-bit samples count; edges elsewhere are ignored.

Decomposition:
- Package rx_pkg:
  - state encoding, 3-bit localparams.
  - OVERSAMPLE_DEF and DATA_BITS_DEF defaults.
  - function majority3.
- Sub-module rx_sync2: the 2-FF synchroniser with preset-to-1 on i_rst_n.
- Instantiated alongside, not inside: the existing receive SIPO. Connect o_shift, o_onedetected and o_zerodetected directly to its inputs.

Test Plan:
- Nominal frame: OVERSAMPLE=16, 8N1, byte 0xA5 sent LSB first with clean edges.
  - expect 8 o_shift pulses with o_onedetected pattern 1,0,1,0,0,1,0,1.
  - expect the SIPO to read 0xA5.
  - expect one o_data_valid pulse; o_parity_err=0 and o_framing_err=0.
- False start: i_rx low for 4 ticks, then high.
  - expect o_busy high for under 10 ticks, no o_shift, return to IDLE.
  - a following 0x3C frame is received correctly.
- Glitch rejection: data bit 0x01 sent with a 1-tick low glitch at scnt=M inside bit0.
  - expect the vote to give 1 and the SIPO to read 0x01.
- Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 sent with parity bit 0 (wrong, since 0x07 has three 1s so even parity is 1).
  - expect o_data_valid together with o_parity_err=1.
  - with parity bit 1: o_parity_err=0.
- Framing and break: 0x55 with the stop bit at 0, line held low for 3 bit times.
  - expect a single o_framing_err pulse, no o_data_valid.
  - o_busy stays high until the line returns high; the next 0xFF frame is received correctly.
- Reset mid-frame: assert i_rst_n=0 during DATA bit 4 of 0x81.
  - expect all outputs 0 immediately.
  - after release, no o_data_valid for the aborted frame; the next 0x18 frame is received correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the UART receive sequencer: state encoding,
// default geometry and the small bit-level helpers used by the FSM.
package rx_pkg;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS_DEF  = 8;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_START     = 3'd1;
   localparam logic [2:0] ST_DATA      = 3'd2;
   localparam logic [2:0] ST_PARITY    = 3'd3;
   localparam logic [2:0] ST_STOP      = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Parity bit the transmitter should have sent, given the XOR of the data bits.
   function automatic logic parity_expect(input logic acc, input logic odd);
      return acc ^ odd;
   endfunction

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the raw serial line; presets to the idle level
// so a reset never looks like a start bit.
module rx_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Metastability filter chain, preset high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive-side frame sequencer: start qualification, mid-bit majority vote,
// SIPO strobes, optional parity and stop-bit checking.
module rx_frame_ctrl
   import rx_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic i_baudclk,
   input  logic i_rst_n,
   input  logic i_sample_tick,
   input  logic i_rx,
   output logic o_shift,
   output logic o_onedetected,
   output logic o_zerodetected,
   output logic o_data_valid,
   output logic o_parity_err,
   output logic o_framing_err,
   output logic o_busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam logic [SW-1:0] S_ZERO  = {SW{1'b0}};
   localparam logic [SW-1:0] S_ONE   = SW'(1);
   localparam logic [SW-1:0] S_EARLY = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_MID   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] S_DEC   = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [2:0]    B_LAST  = 3'(DATA_BITS - 1);
   localparam logic          PAR_EN  = (PARITY_EN != 0) ? 1'b1 : 1'b0;
   localparam logic          PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

   logic          rx_s;
   logic [2:0]    state_r, next_state_s;
   logic [SW-1:0] scnt_r, scnt_nx_s, scnt_adv_s;
   logic [2:0]    bcnt_r, bcnt_nx_s;
   logic [1:0]    samp_r, samp_nx_s;
   logic          par_r, par_nx_s;
   logic          mism_r, mism_nx_s;
   logic          wrap_s, dec_s, vote_s;
   logic          shift_r, one_r, zero_r, dv_r, perr_r, ferr_r, busy_r;
   logic          shift_nx_s, one_nx_s, zero_nx_s, dv_nx_s, perr_nx_s, ferr_nx_s, busy_nx_s;

   rx_sync2 u_sync (
      .clk   (i_baudclk),
      .rst_n (i_rst_n),
      .d     (i_rx),
      .q     (rx_s)
   );

   assign wrap_s     = i_sample_tick && (scnt_r == S_LAST);
   assign dec_s      = i_sample_tick && (scnt_r == S_DEC);
   assign vote_s     = majority3(samp_r[0], samp_r[1], rx_s);
   assign scnt_adv_s = !i_sample_tick ? scnt_r : ((scnt_r == S_LAST) ? S_ZERO : scnt_r + S_ONE);

   // State register.
   always_ff @(posedge i_baudclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode; every transition is qualified by a sample tick.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (i_sample_tick && !rx_s) next_state_s = ST_START;
            else                        next_state_s = ST_IDLE;
         end
         ST_START: begin
            if (dec_s && vote_s) next_state_s = ST_IDLE;
            else if (wrap_s)     next_state_s = ST_DATA;
            else                 next_state_s = ST_START;
         end
         ST_DATA: begin
            if (wrap_s && (bcnt_r == B_LAST)) next_state_s = PAR_EN ? ST_PARITY : ST_STOP;
            else                              next_state_s = ST_DATA;
         end
         ST_PARITY: begin
            if (wrap_s) next_state_s = ST_STOP;
            else        next_state_s = ST_PARITY;
         end
         ST_STOP: begin
            if (dec_s) next_state_s = vote_s ? ST_IDLE : ST_WAIT_IDLE;
            else       next_state_s = ST_STOP;
         end
         ST_WAIT_IDLE: begin
            if (i_sample_tick && rx_s) next_state_s = ST_IDLE;
            else                       next_state_s = ST_WAIT_IDLE;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Counters, vote samples, parity and the next values of the registered outputs.
   always_comb begin
      scnt_nx_s  = scnt_r;
      bcnt_nx_s  = bcnt_r;
      par_nx_s   = par_r;
      mism_nx_s  = mism_r;
      busy_nx_s  = busy_r;
      shift_nx_s = 1'b0;
      one_nx_s   = 1'b0;
      zero_nx_s  = 1'b0;
      dv_nx_s    = 1'b0;
      perr_nx_s  = 1'b0;
      ferr_nx_s  = 1'b0;
      samp_nx_s  = samp_r;
      if (i_sample_tick && (scnt_r == S_EARLY))    samp_nx_s[0] = rx_s;
      else if (i_sample_tick && (scnt_r == S_MID)) samp_nx_s[1] = rx_s;
      else                                         samp_nx_s    = samp_r;

      case (state_r)
         ST_IDLE: begin
            bcnt_nx_s = 3'd0;
            par_nx_s  = 1'b0;
            mism_nx_s = 1'b0;
            if (i_sample_tick && !rx_s) begin
               scnt_nx_s = S_ONE;
               busy_nx_s = 1'b1;
            end else begin
               scnt_nx_s = S_ZERO;
               busy_nx_s = 1'b0;
            end
         end
         ST_START: begin
            bcnt_nx_s = 3'd0;
            if (dec_s && vote_s) begin
               scnt_nx_s = S_ZERO;
               busy_nx_s = 1'b0;
            end else begin
               scnt_nx_s = scnt_adv_s;
               busy_nx_s = 1'b1;
            end
         end
         ST_DATA: begin
            scnt_nx_s = scnt_adv_s;
            if (dec_s) begin
               shift_nx_s = 1'b1;
               one_nx_s   = vote_s;
               zero_nx_s  = !vote_s;
               par_nx_s   = par_r ^ vote_s;
            end else begin
               par_nx_s   = par_r;
            end
            if (wrap_s) bcnt_nx_s = bcnt_r + 3'd1;
            else        bcnt_nx_s = bcnt_r;
         end
         ST_PARITY: begin
            scnt_nx_s = scnt_adv_s;
            if (dec_s) mism_nx_s = (vote_s != parity_expect(par_r, PAR_ODD));
            else       mism_nx_s = mism_r;
         end
         ST_STOP: begin
            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
            if (dec_s) begin
               scnt_nx_s = S_ZERO;
               if (vote_s) begin
                  dv_nx_s   = 1'b1;
                  perr_nx_s = mism_r;
                  busy_nx_s = 1'b0;
               end else begin
                  ferr_nx_s = 1'b1;
                  busy_nx_s = 1'b1;
               end
            end else begin
               scnt_nx_s = scnt_adv_s;
            end
         end
         ST_WAIT_IDLE: begin
            scnt_nx_s = S_ZERO;
            if (i_sample_tick && rx_s) busy_nx_s = 1'b0;
            else                       busy_nx_s = 1'b1;
         end
         default: begin
            scnt_nx_s = S_ZERO;
            busy_nx_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge i_baudclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scnt_r  <= S_ZERO;
         bcnt_r  <= 3'd0;
         samp_r  <= 2'b00;
         par_r   <= 1'b0;
         mism_r  <= 1'b0;
         shift_r <= 1'b0;
         one_r   <= 1'b0;
         zero_r  <= 1'b0;
         dv_r    <= 1'b0;
         perr_r  <= 1'b0;
         ferr_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         scnt_r  <= scnt_nx_s;
         bcnt_r  <= bcnt_nx_s;
         samp_r  <= samp_nx_s;
         par_r   <= par_nx_s;
         mism_r  <= mism_nx_s;
         shift_r <= shift_nx_s;
         one_r   <= one_nx_s;
         zero_r  <= zero_nx_s;
         dv_r    <= dv_nx_s;
         perr_r  <= perr_nx_s;
         ferr_r  <= ferr_nx_s;
         busy_r  <= busy_nx_s;
      end
   end

   assign o_shift        = shift_r;
   assign o_onedetected  = one_r;
   assign o_zerodetected = zero_r;
   assign o_data_valid   = dv_r;
   assign o_parity_err   = perr_r;
   assign o_framing_err  = ferr_r;
   assign o_busy         = busy_r;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: an 8N1 instance and an 8E1 instance,
// each with its own serial line, expected-frame queue and SIPO model.
module tb_rx_frame_ctrl;

   localparam int OS = 16;

   typedef struct packed {
      logic       ferr;
      logic [7:0] data;
      logic       perr;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic tick  = 1'b0;
   logic rx_n  = 1'b1;
   logic rx_p  = 1'b1;
   logic shift_n, one_n, zero_n, dv_n, perr_n, ferr_n, busy_n;
   logic shift_p, one_p, zero_p, dv_p, perr_p, ferr_p, busy_p;

   exp_t       q_n[$];
   exp_t       q_p[$];
   exp_t       e_n, e_p;
   bit         have_n, have_p;
   logic [7:0] sipo_n, sipo_p;
   int         nsh_n, nsh_p;
   int         busy_ticks_n;
   int         n_tests = 0;
   int         n_fail  = 0;

   rx_frame_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
      .i_baudclk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_rx(rx_n),
      .o_shift(shift_n), .o_onedetected(one_n), .o_zerodetected(zero_n),
      .o_data_valid(dv_n), .o_parity_err(perr_n), .o_framing_err(ferr_n), .o_busy(busy_n));

   rx_frame_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .i_baudclk(clk), .i_rst_n(rst_n), .i_sample_tick(tick), .i_rx(rx_p),
      .o_shift(shift_p), .o_onedetected(one_p), .o_zerodetected(zero_p),
      .o_data_valid(dv_p), .o_parity_err(perr_p), .o_framing_err(ferr_p), .o_busy(busy_p));

   always #5 clk = ~clk;

   // Sample ticks with random spacing of 3..5 clocks; changes just after the rising edge.
   initial begin
      int gap;
      gap = 0;
      forever begin
         @(posedge clk);
         #1;
         if (gap == 0) begin
            tick = 1'b1;
            gap  = $urandom_range(4, 2);
         end else begin
            tick = 1'b0;
            gap  = gap - 1;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon_step(input string tag, input logic rstn, input logic sh, input logic one,
                           input logic zero, input logic dv, input logic pe, input logic fe,
                           input bit have, input exp_t e, inout logic [7:0] sipo, inout int nsh);
      if (!rstn) begin
         nsh = 0;
      end else begin
         if (sh) begin
            check({tag, "_onehot"}, 32'(one ^ zero), 32'd1);
            sipo = {one, sipo[7:1]};
            nsh++;
         end
         if (sh || dv || fe)
            check({tag, "_exclusive"}, 32'(int'(sh) + int'(dv) + int'(fe)), 32'd1);
         if (pe) check({tag, "_perr_with_dv"}, 32'(dv), 32'd1);
         if (dv || fe) begin
            check({tag, "_pending"}, 32'(have), 32'd1);
            if (have) begin
               check({tag, "_ferr"}, 32'(fe), 32'(e.ferr));
               check({tag, "_shifts"}, 32'(nsh), 32'd8);
               if (dv) begin
                  check({tag, "_data"}, 32'(sipo), 32'(e.data));
                  check({tag, "_perr"}, 32'(pe), 32'(e.perr));
               end
            end
            nsh = 0;
         end
      end
   endtask

   // Monitors: pop the expected frame when a DUT reports completion.
   initial begin
      nsh_n = 0;
      sipo_n = 8'h00;
      forever begin
         @(negedge clk);
         have_n = 1'b0;
         e_n    = '0;
         if (rst_n && (dv_n || ferr_n) && q_n.size() > 0) begin
            e_n    = q_n.pop_front();
            have_n = 1'b1;
         end
         mon_step("n", rst_n, shift_n, one_n, zero_n, dv_n, perr_n, ferr_n, have_n, e_n, sipo_n, nsh_n);
         if (busy_n && tick) busy_ticks_n++;
      end
   end

   initial begin
      nsh_p = 0;
      sipo_p = 8'h00;
      forever begin
         @(negedge clk);
         have_p = 1'b0;
         e_p    = '0;
         if (rst_n && (dv_p || ferr_p) && q_p.size() > 0) begin
            e_p    = q_p.pop_front();
            have_p = 1'b1;
         end
         mon_step("p", rst_n, shift_p, one_p, zero_p, dv_p, perr_p, ferr_p, have_p, e_p, sipo_p, nsh_p);
      end
   end

   task automatic wait_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clk);
         if (tick) k++;
      end
      #1;
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) rx_p = v;
      else     rx_n = v;
   endtask

   // One bit time; g>0 inverts the line for the g-th tick of the bit only.
   task automatic drive_bit(input bit sel, input logic v, input int g);
      set_line(sel, v);
      if (g == 0) begin
         wait_ticks(OS);
      end else begin
         wait_ticks(g - 1);
         set_line(sel, ~v);
         wait_ticks(1);
         set_line(sel, v);
         wait_ticks(OS - g);
      end
   endtask

   task automatic idle(input bit sel, input int n);
      set_line(sel, 1'b1);
      wait_ticks(n);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par, input logic pbit,
                             input logic stop, input int glitch_bit, input int glitch_at,
                             input int abort_bit);
      exp_t e;
      e.ferr = ~stop;
      e.data = d;
      e.perr = has_par ? (pbit != (^d)) : 1'b0;
      if (abort_bit < 0) begin
         if (sel) q_p.push_back(e);
         else     q_n.push_back(e);
      end
      drive_bit(sel, 1'b0, 0);
      for (int i = 0; i < 8; i++) begin
         if (i == abort_bit) begin
            set_line(sel, d[i]);
            wait_ticks(OS / 2);
            rst_n = 1'b0;
            @(negedge clk);
            check("rst_mid_outs_n", 32'({shift_n, one_n, zero_n, dv_n, perr_n, ferr_n, busy_n}), 32'd0);
            check("rst_mid_outs_p", 32'({shift_p, one_p, zero_p, dv_p, perr_p, ferr_p, busy_p}), 32'd0);
            set_line(sel, 1'b1);
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end
         drive_bit(sel, d[i], (i == glitch_bit) ? glitch_at : 0);
      end
      if (has_par) drive_bit(sel, pbit, 0);
      drive_bit(sel, stop, 0);
   endtask

   initial begin
      logic [7:0] d;
      logic       stop;
      int         gb;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("reset_outs_n", 32'({shift_n, one_n, zero_n, dv_n, perr_n, ferr_n, busy_n}), 32'd0);
      check("reset_outs_p", 32'({shift_p, one_p, zero_p, dv_p, perr_p, ferr_p, busy_p}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ticks(4);
      @(negedge clk);
      check("post_reset_busy_n", 32'(busy_n), 32'd0);

      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 0, -1);
      idle(1'b0, 3);

      busy_ticks_n = 0;
      set_line(1'b0, 1'b0);
      wait_ticks(4);
      set_line(1'b0, 1'b1);
      wait_ticks(12);
      check("false_start_busy_ticks", 32'((busy_ticks_n > 0) && (busy_ticks_n < 10)), 32'd1);
      @(negedge clk);
      check("false_start_idle", 32'(busy_n), 32'd0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, 0, -1);
      idle(1'b0, 2);

      send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 0, OS / 2 + 1, -1);
      idle(1'b0, 2);

      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, -1, 0, -1);
      wait_ticks(2 * OS);
      @(negedge clk);
      check("break_busy_held", 32'(busy_n), 32'd1);
      idle(1'b0, 4);
      @(negedge clk);
      check("break_released", 32'(busy_n), 32'd0);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, -1, 0, -1);
      idle(1'b0, 2);

      send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, -1, 0, 4);
      idle(1'b0, 4);
      send_frame(1'b0, 8'h18, 1'b0, 1'b0, 1'b1, -1, 0, -1);
      idle(1'b0, 2);

      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1, 0, -1);
      idle(1'b1, 3);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1, 0, -1);
      idle(1'b1, 3);

      for (int i = 0; i < 20; i++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(5, 0) != 0);
         gb   = ($urandom_range(1, 0) != 0) ? int'($urandom_range(7, 0)) : -1;
         send_frame(1'b0, d, 1'b0, 1'b0, stop, gb, int'($urandom_range(6, 2)), -1);
         idle(1'b0, stop ? int'($urandom_range(6, 0)) : int'($urandom_range(6, 2)));
      end
      for (int i = 0; i < 12; i++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(5, 0) != 0);
         gb   = ($urandom_range(1, 0) != 0) ? int'($urandom_range(7, 0)) : -1;
         send_frame(1'b1, d, 1'b1, 1'($urandom), stop, gb, int'($urandom_range(6, 2)), -1);
         idle(1'b1, stop ? int'($urandom_range(6, 0)) : int'($urandom_range(6, 2)));
      end

      wait_ticks(OS);
      check("drain_q_n", 32'(q_n.size()), 32'd0);
      check("drain_q_p", 32'(q_p.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
